// File: rtl/grab_trig_pkg.sv
// -----------------------------------------------------------------------------
// grab_trig_pkg
// Shared encodings for the grab trigger qualifier:
//   - grab source (grab_mode) and hardware activation (trig_act) codes, kept
//     numerically identical to the verification core package;
//   - FSM state enum for grab_trigger_qualifier;
//   - helper telling whether an activation selects an edge (counted as an
//     event for rejection) rather than a level.
// -----------------------------------------------------------------------------
package grab_trig_pkg;

    // Grab source encodings. Codes 0 and 5-7 never trigger.
    localparam logic [2:0] GRAB_SRC_IMMEDIATE = 3'd1;
    localparam logic [2:0] GRAB_SRC_HW_TRIG   = 3'd2;
    localparam logic [2:0] GRAB_SRC_SW_TRIG   = 3'd3;
    localparam logic [2:0] GRAB_SRC_SFNC      = 3'd4;

    // Hardware activation encodings. Codes 5-7 never trigger.
    localparam logic [2:0] TRIG_ACT_RISING    = 3'd0;
    localparam logic [2:0] TRIG_ACT_FALLING   = 3'd1;
    localparam logic [2:0] TRIG_ACT_ANY       = 3'd2;
    localparam logic [2:0] TRIG_ACT_LEVEL_HI  = 3'd3;
    localparam logic [2:0] TRIG_ACT_LEVEL_LO  = 3'd4;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ARMED    = 3'd1,
        DELAY    = 3'd2,
        REQ      = 3'd3,
        BUSY     = 3'd4
    } grab_state_e;

    // Edge activations produce discrete trigger events; level activations
    // do not and are never counted as missed triggers.
    function automatic logic is_edge_act(input logic [2:0] act);
        return (act == TRIG_ACT_RISING) || (act == TRIG_ACT_FALLING) ||
               (act == TRIG_ACT_ANY);
    endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// -----------------------------------------------------------------------------
// trig_sync_edge
// Brings the asynchronous hw_trig pin into sys_clk, optionally filters it,
// and produces one registered qualification strobe for the selected
// activation (edge or level).
//
// Configuration macro: GRAB_TRIG_DEBOUNCE_EN
//   defined   -> glitch filter after the synchronizer; the filtered level
//                follows the input only after DEB_CYCLES stable cycles.
//   undefined -> no filter.
//
// Ports:
//   sys_clk      in   clock
//   sys_reset_n  in   asynchronous active-low reset
//   hw_trig      in   asynchronous trigger pin
//   trig_act     in   [2:0] activation select (latched by the caller)
//   hw_qual      out  registered qualification strobe / level
// -----------------------------------------------------------------------------
module trig_sync_edge
    import grab_trig_pkg::*;
#(
    parameter int DEB_CYCLES = 8
) (
    input  logic       sys_clk,
    input  logic       sys_reset_n,
    input  logic       hw_trig,
    input  logic [2:0] trig_act,
    output logic       hw_qual
);

`ifdef GRAB_TRIG_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_hw_qual;
    logic w_filt;
    logic w_rise;
    logic w_fall;
    logic w_qual;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= hw_trig;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEB_EN && (DEB_CYCLES > 0)) begin : g_deb
            localparam int CNT_W = $clog2(DEB_CYCLES + 1);
            logic             r_filt;
            logic [CNT_W-1:0] r_cnt;

            // The counter measures how long the synchronized input has
            // disagreed with the filtered level; any agreement restarts it.
            always_ff @(posedge sys_clk or negedge sys_reset_n) begin
                if (!sys_reset_n) begin
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else if (r_sync2 == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_filt <= r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
            end

            assign w_filt = r_filt;
        end else begin : g_no_deb
            assign w_filt = r_sync2;
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_hist    <= 1'b0;
            r_hw_qual <= 1'b0;
        end else begin
            r_hist    <= w_filt;
            r_hw_qual <= w_qual;
        end
    end

    assign w_rise = w_filt & ~r_hist;
    assign w_fall = ~w_filt & r_hist;

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; without it the unlisted codes would infer a latch.
    always_comb begin
        w_qual = 1'b0;
        case (trig_act)
            TRIG_ACT_RISING:   w_qual = w_rise;
            TRIG_ACT_FALLING:  w_qual = w_fall;
            TRIG_ACT_ANY:      w_qual = w_rise | w_fall;
            TRIG_ACT_LEVEL_HI: w_qual = w_filt;
            TRIG_ACT_LEVEL_LO: w_qual = ~w_filt;
            default:           w_qual = 1'b0;
        endcase
    end

    assign hw_qual = r_hw_qual;

endmodule

// File: rtl/grab_trigger_qualifier.sv
// -----------------------------------------------------------------------------
// grab_trigger_qualifier
// Qualifies acquisition triggers and issues one grab request per accepted
// trigger. Triggers arriving while a grab is pending or running are rejected
// and counted.
//
// Configuration macro: GRAB_TRIG_DEBOUNCE_EN (hw_trig glitch filter, see
// trig_sync_edge).
//
// Ports:
//   sys_clk          in   clock
//   sys_reset_n      in   asynchronous active-low reset
//   grab_en          in   arms the block
//   grab_mode        in   [2:0] grab source
//   trig_act         in   [2:0] hardware activation
//   trig_delay       in   [DLY_W-1:0] cycles from qualification to request
//   hw_trig          in   asynchronous trigger pin
//   sw_trig          in   software trigger pulse
//   sfnc_trig        in   SFNC acquisition-start pulse
//   grab_ack         in   downstream accepted the request
//   grab_done        in   end of readout pulse
//   clr_stat         in   clears trig_overrun / trig_missed_cnt
//   grab_req         out  request, held until grab_ack
//   armed            out  high while waiting for a trigger
//   trig_overrun     out  sticky rejected-trigger flag
//   trig_missed_cnt  out  [MISS_W-1:0] saturating rejected-trigger count
// -----------------------------------------------------------------------------
module grab_trigger_qualifier
    import grab_trig_pkg::*;
#(
    parameter int DLY_W      = 24,
    parameter int MISS_W     = 16,
    parameter int DEB_CYCLES = 8
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              grab_en,
    input  logic [2:0]        grab_mode,
    input  logic [2:0]        trig_act,
    input  logic [DLY_W-1:0]  trig_delay,
    input  logic              hw_trig,
    input  logic              sw_trig,
    input  logic              sfnc_trig,
    input  logic              grab_ack,
    input  logic              grab_done,
    input  logic              clr_stat,
    output logic              grab_req,
    output logic              armed,
    output logic              trig_overrun,
    output logic [MISS_W-1:0] trig_missed_cnt
);

    grab_state_e       r_state;
    grab_state_e       w_state_nxt;
    logic [2:0]        r_mode;
    logic [2:0]        r_act;
    logic [DLY_W-1:0]  r_dly_cnt;
    logic              r_grab_req;
    logic              r_armed;
    logic              r_overrun;
    logic [MISS_W-1:0] r_missed;

    logic w_hw_qual;
    logic w_trig_qual;
    logic w_trig_event;
    logic w_reject;

    trig_sync_edge #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_trig_sync_edge (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .hw_trig     (hw_trig),
        .trig_act    (r_act),
        .hw_qual     (w_hw_qual)
    );

    // Source and activation are frozen on arming so a reconfiguration can
    // only take effect after the block has been disabled again.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_mode <= 3'd0;
            r_act  <= TRIG_ACT_RISING;
        end else if ((r_state == DISABLED) && grab_en) begin
            r_mode <= grab_mode;
            r_act  <= trig_act;
        end
    end

    // Qualification drives ARMED forward; "event" is the subset that counts
    // as a discrete trigger when rejected (IMMEDIATE and levels excluded).
    // Only the selected source produces events.
    always_comb begin
        w_trig_qual  = 1'b0;
        w_trig_event = 1'b0;
        case (r_mode)
            GRAB_SRC_IMMEDIATE: w_trig_qual = 1'b1;
            GRAB_SRC_HW_TRIG: begin
                w_trig_qual  = w_hw_qual;
                w_trig_event = w_hw_qual && is_edge_act(r_act);
            end
            GRAB_SRC_SW_TRIG: begin
                w_trig_qual  = sw_trig;
                w_trig_event = sw_trig;
            end
            GRAB_SRC_SFNC: begin
                w_trig_qual  = sfnc_trig;
                w_trig_event = sfnc_trig;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DISABLED: if (grab_en) w_state_nxt = ARMED;
            ARMED: begin
                if (!grab_en)         w_state_nxt = DISABLED;
                else if (w_trig_qual) w_state_nxt = (trig_delay != '0) ? DELAY : REQ;
            end
            DELAY: begin
                if (!grab_en)                      w_state_nxt = DISABLED;
                else if (r_dly_cnt == DLY_W'(1))   w_state_nxt = REQ;
            end
            // A same-cycle grab_done is dropped here; only grab_ack counts.
            REQ:  if (grab_ack) w_state_nxt = BUSY;
            BUSY: if (grab_done) w_state_nxt = grab_en ? ARMED : DISABLED;
            default: w_state_nxt = DISABLED;
        endcase
    end

    // armed and grab_req are decoded from the next state so they change on
    // the same edge as the state register, glitch-free and without lag.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state    <= DISABLED;
            r_armed    <= 1'b0;
            r_grab_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_armed    <= (w_state_nxt == ARMED);
            r_grab_req <= (w_state_nxt == REQ);
        end
    end

    // The counter reloads every ARMED cycle and then counts down in DELAY;
    // the exit at 1 gives exactly trig_delay cycles spent in DELAY.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_dly_cnt <= '0;
        end else if (r_state == ARMED) begin
            r_dly_cnt <= trig_delay;
        end else if (r_state == DELAY) begin
            r_dly_cnt <= r_dly_cnt - DLY_W'(1);
        end
    end

    assign w_reject = w_trig_event &&
                      ((r_state == DELAY) || (r_state == REQ) || (r_state == BUSY));

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_overrun <= 1'b0;
            r_missed  <= '0;
        end else if (clr_stat) begin
            r_overrun <= 1'b0;
            r_missed  <= '0;
        end else if (w_reject) begin
            r_overrun <= 1'b1;
            if (r_missed != '1) r_missed <= r_missed + MISS_W'(1);
        end
    end

    assign grab_req        = r_grab_req;
    assign armed           = r_armed;
    assign trig_overrun    = r_overrun;
    assign trig_missed_cnt = r_missed;

endmodule

// File: tb/tb_grab_trigger_qualifier.sv
// -----------------------------------------------------------------------------
// tb_grab_trigger_qualifier
// Directed bench for grab_trigger_qualifier. Two instances share all inputs:
// the default one and one with a 2-bit missed counter for saturation.
// A transaction-level model (flags + a delay countdown + an unbounded miss
// tally) predicts outputs; one process compares every negedge.
// -----------------------------------------------------------------------------
module tb_grab_trigger_qualifier;

    localparam int DLY_W = 24;

    logic             sys_clk;
    logic             sys_reset_n;
    logic             grab_en;
    logic [2:0]       grab_mode;
    logic [2:0]       trig_act;
    logic [DLY_W-1:0] trig_delay;
    logic             hw_trig;
    logic             sw_trig;
    logic             sfnc_trig;
    logic             grab_ack;
    logic             grab_done;
    logic             clr_stat;

    logic             grab_req,   armed,   trig_overrun;
    logic [15:0]      trig_missed_cnt;
    logic             grab_req_2, armed_2, trig_overrun_2;
    logic [1:0]       trig_missed_cnt_2;

    int checks = 0;
    int errors = 0;

    grab_trigger_qualifier #(.DLY_W(DLY_W), .MISS_W(16), .DEB_CYCLES(8)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .grab_en(grab_en),
        .grab_mode(grab_mode), .trig_act(trig_act), .trig_delay(trig_delay),
        .hw_trig(hw_trig), .sw_trig(sw_trig), .sfnc_trig(sfnc_trig),
        .grab_ack(grab_ack), .grab_done(grab_done), .clr_stat(clr_stat),
        .grab_req(grab_req), .armed(armed), .trig_overrun(trig_overrun),
        .trig_missed_cnt(trig_missed_cnt)
    );

    grab_trigger_qualifier #(.DLY_W(DLY_W), .MISS_W(2), .DEB_CYCLES(8)) dut_sat (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .grab_en(grab_en),
        .grab_mode(grab_mode), .trig_act(trig_act), .trig_delay(trig_delay),
        .hw_trig(hw_trig), .sw_trig(sw_trig), .sfnc_trig(sfnc_trig),
        .grab_ack(grab_ack), .grab_done(grab_done), .clr_stat(clr_stat),
        .grab_req(grab_req_2), .armed(armed_2), .trig_overrun(trig_overrun_2),
        .trig_missed_cnt(trig_missed_cnt_2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Whole-pipeline view: the hw pin value seen at edge n-3 against the one
    // at edge n-4 decides a hw trigger at edge n.
    logic [3:0] m_hw;          // m_hw[i] = hw_trig sampled i+1 edges ago
    bit         m_on;          // enabled (anything but disabled)
    bit         m_req;         // request outstanding
    bit         m_busy;        // readout running
    int         m_wait;        // remaining delay cycles, -1 when not delaying
    int         m_raw;         // unbounded rejected-trigger tally
    bit         m_ovr;
    logic [2:0] m_mode, m_act;

    bit m_edge, m_level, m_qual, m_evt, m_inflight;

    always_comb begin
        m_edge  = 1'b0;
        m_level = 1'b0;
        case (m_act)
            3'd0: m_edge  = m_hw[2] && !m_hw[3];
            3'd1: m_edge  = !m_hw[2] && m_hw[3];
            3'd2: m_edge  = m_hw[2] != m_hw[3];
            3'd3: m_level = m_hw[2];
            3'd4: m_level = !m_hw[2];
            default: ;
        endcase
        m_qual = 1'b0;
        m_evt  = 1'b0;
        case (m_mode)
            3'd1: m_qual = 1'b1;
            3'd2: begin m_qual = m_edge || m_level; m_evt = m_edge; end
            3'd3: begin m_qual = sw_trig;   m_evt = sw_trig;   end
            3'd4: begin m_qual = sfnc_trig; m_evt = sfnc_trig; end
            default: ;
        endcase
        m_inflight = m_req || m_busy || (m_wait >= 0);
    end

    always @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            m_hw <= '0; m_on <= 0; m_req <= 0; m_busy <= 0; m_wait <= -1;
            m_raw <= 0; m_ovr <= 0; m_mode <= 3'd0; m_act <= 3'd0;
        end else begin
            m_hw <= {m_hw[2:0], hw_trig};
            if (clr_stat) begin
                m_raw <= 0; m_ovr <= 0;
            end else if (m_evt && m_inflight) begin
                m_raw <= m_raw + 1; m_ovr <= 1;
            end
            if (!m_on) begin
                if (grab_en) begin m_on <= 1; m_mode <= grab_mode; m_act <= trig_act; end
            end else if (m_req) begin
                if (grab_ack) begin m_req <= 0; m_busy <= 1; end
            end else if (m_busy) begin
                if (grab_done) begin m_busy <= 0; m_on <= grab_en; end
            end else if (m_wait >= 0) begin
                if (!grab_en)        begin m_wait <= -1; m_on <= 0; end
                else if (m_wait <= 1) begin m_wait <= -1; m_req <= 1; end
                else                   m_wait <= m_wait - 1;
            end else begin
                if (!grab_en)                m_on <= 0;
                else if (m_qual && trig_delay == 0) m_req <= 1;
                else if (m_qual)              m_wait <= int'(trig_delay);
            end
        end
    end

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(negedge sys_clk) begin
        check("grab_req",  grab_req,  m_req);
        check("armed",     armed,     m_on && !m_req && !m_busy && (m_wait < 0));
        check("overrun",   trig_overrun, m_ovr);
        check("missed",    trig_missed_cnt, sat(m_raw, 65535));
        check("grab_req_w2", grab_req_2, m_req);
        check("overrun_w2",  trig_overrun_2, m_ovr);
        check("missed_w2",   trig_missed_cnt_2, sat(m_raw, 3));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(input int max_ticks, output int n);
        n = 0;
        while (!grab_req && n < max_ticks) begin
            tick();
            n++;
        end
        check("req_seen", grab_req, 1);
    endtask

    task automatic pulse_sw();
        sw_trig = 1; tick(); sw_trig = 0; tick();
    endtask

    task automatic ack_then_done();
        grab_ack = 1; tick(); grab_ack = 0;
        ticks(2);
        grab_done = 1; tick(); grab_done = 0;
    endtask

    task automatic disable_block();
        grab_en = 0; ticks(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        sys_reset_n = 0; grab_en = 0; grab_mode = 3'd0; trig_act = 3'd0;
        trig_delay = '0; hw_trig = 0; sw_trig = 0; sfnc_trig = 0;
        grab_ack = 0; grab_done = 0; clr_stat = 0;

        // Reset, then stay disabled without grab_en.
        ticks(3);
        check("rst_armed", armed, 0);
        check("rst_req",   grab_req, 0);
        sys_reset_n = 1;
        ticks(3);
        check("idle_not_armed", armed, 0);

        // HW_TRIG RISING, delay 0: request after the 4th edge, held until ack.
        grab_mode = 3'd2; trig_act = 3'd0; grab_en = 1;
        ticks(2);
        check("hw_armed", armed, 1);
        hw_trig = 1;
        wait_req(20, n);
        check("hw_rise_latency", n, 4);
        ticks(10);
        check("req_held", grab_req, 1);
        grab_ack = 1; tick(); grab_ack = 0;
        check("req_drop_on_ack", grab_req, 0);
        ticks(2);
        grab_done = 1; tick(); grab_done = 0;
        check("rearm_after_done", armed, 1);
        hw_trig = 0;
        ticks(6);

        // HW_TRIG FALLING, delay 5.
        disable_block();
        trig_act = 3'd1; trig_delay = 24'd5; grab_en = 1;
        ticks(4);
        hw_trig = 1;
        ticks(20);
        check("fall_no_req_on_rise", grab_req, 0);
        hw_trig = 0;
        wait_req(40, n);
        check("hw_fall_delay_latency", n, 9);
        ack_then_done();
        hw_trig = 1; ticks(4); hw_trig = 0;
        ticks(6);
        grab_en = 0;
        ticks(10);
        check("abort_no_req", grab_req, 0);
        check("abort_disabled", armed, 0);
        trig_delay = '0;

        // SW_TRIG: rejections during BUSY, clr_stat priority, saturation.
        grab_mode = 3'd3; grab_en = 1;
        ticks(2);
        clr_stat = 1; tick(); clr_stat = 0;
        sw_trig = 1; tick(); sw_trig = 0;
        check("sw_latency", grab_req, 1);
        grab_ack = 1; tick(); grab_ack = 0;
        for (int i = 0; i < 3; i++) pulse_sw();
        check("sw_missed3", trig_missed_cnt, 3);
        check("sw_overrun", trig_overrun, 1);
        sw_trig = 1; clr_stat = 1; tick(); sw_trig = 0; clr_stat = 0;
        check("clr_priority_cnt", trig_missed_cnt, 0);
        check("clr_priority_ovr", trig_overrun, 0);
        for (int i = 0; i < 5; i++) pulse_sw();
        check("missed5_w16", trig_missed_cnt, 5);
        check("missed5_w2_sat", trig_missed_cnt_2, 3);
        grab_done = 1; tick(); grab_done = 0;
        check("sw_rearm", armed, 1);
        clr_stat = 1; tick(); clr_stat = 0;

        // IMMEDIATE: back-to-back grabs, no missed triggers.
        disable_block();
        grab_mode = 3'd1; grab_en = 1;
        tick();
        for (int g = 0; g < 4; g++) begin
            wait_req(8, n);
            check("imm_gap", n, 1);
            tick();
            ack_then_done();
            check("imm_armed_after_done", armed, 1);
        end
        wait_req(8, n);
        grab_en = 0;
        tick();
        check("req_survives_en_drop", grab_req, 1);
        ack_then_done();
        check("imm_end_disabled", armed, 0);
        check("imm_no_missed", trig_missed_cnt, 0);

        // HW_TRIG with invalid activation 6: never requests.
        tick();
        grab_mode = 3'd2; trig_act = 3'd6; grab_en = 1;
        ticks(2);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            hw_trig = ~hw_trig;
            for (int j = 0; j < 3; j++) begin
                tick();
                if (grab_req) seen = 1;
            end
        end
        check("invalid_act_no_req", seen, 0);
        hw_trig = 0;
        ticks(6);

        // Reset asserted mid-BUSY.
        disable_block();
        grab_mode = 3'd3; grab_en = 1;
        ticks(2);
        sw_trig = 1; tick(); sw_trig = 0;
        grab_ack = 1; tick(); grab_ack = 0;
        pulse_sw();
        check("pre_rst_missed", trig_missed_cnt, 1);
        #1;
        sys_reset_n = 0;
        grab_en = 0;
        #1;
        check("async_rst_ovr", trig_overrun, 0);
        check("async_rst_cnt", trig_missed_cnt, 0);
        check("async_rst_req", grab_req, 0);
        ticks(2);
        sys_reset_n = 1;
        ticks(3);
        check("post_rst_idle", armed, 0);
        grab_en = 1;
        tick();
        check("post_rst_rearm", armed, 1);
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
